// File: rtl/cntr8_cmd_pkg.sv
// Shared types for the cntr8 command sequencer: opcodes, executor states, command word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cntr8_cmd_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_WAIT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_INC  = 2'b10,
    ST_WAIT = 2'b11
  } state_e;

  // Command word as stored in the FIFO: {op[9:8], data[7:0]}
  typedef struct packed {
    op_e        op;
    logic [7:0] data;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/cntr8_cmd_seq_fifo.sv
// Single-clock FIFO holding DEPTH words of W bits, read data is the current head.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdat,
  output logic [W-1:0]  rdat,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdat    = mem[rptr];

  // Pointers wrap naturally since DEPTH is a power of two; level tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop_ok)  rptr <= rptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Storage array, no reset needed since empty/level guard every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdat;
  end

endmodule

// File: rtl/cntr8_cmd_seq.sv
// Buffers counter commands and replays them as cycle-accurate inc/load/d_in strobes for cntr8.
// Latency: first strobe appears 2 cycles after acceptance; queued commands run back-to-back.
// Backpressure: o_ready = !full, a same-cycle pop never frees a slot for the incoming command.
module cntr8_cmd_seq
  import cntr8_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [1:0]    i_op,
  input  logic [7:0]    i_data,
  output logic          o_inc,
  output logic          o_load,
  output logic [7:0]    o_d_in,
  output logic          o_busy,
  output logic [AW:0]   o_level
);

  state_e       state, state_nxt;
  logic [7:0]   cnt, cnt_nxt;
  logic         inc_nxt, load_nxt;
  logic [7:0]   d_in_nxt;
  logic         full, empty;
  logic         push, pop;
  logic         last_cycle;
  cmd_t         head;
  cmd_t         wcmd;
  logic [CMD_W-1:0] head_dat;

  assign wcmd    = '{op: op_e'(i_op), data: i_data};
  assign head    = cmd_t'(head_dat);
  assign o_ready = !full;
  assign push    = i_valid && o_ready;

  // cnt holds remaining cycles; 0 encodes 256 and counts down through 255..1
  assign last_cycle = (state != ST_IDLE) && (cnt == 8'd1);
  assign pop        = !empty && ((state == ST_IDLE) || last_cycle);
  assign o_busy     = (state != ST_IDLE) || (o_level != '0);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdat  (wcmd),
    .rdat  (head_dat),
    .full  (full),
    .empty (empty),
    .level (o_level)
  );

  // Next state, run counter and registered strobes; a pop always wins over finishing
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    inc_nxt   = o_inc;
    load_nxt  = o_load;
    d_in_nxt  = o_d_in;
    if (pop) begin
      case (head.op)
        OP_LOAD: begin
          state_nxt = ST_LOAD;
          cnt_nxt   = 8'd1;
          load_nxt  = 1'b1;
          inc_nxt   = 1'b0;
          d_in_nxt  = head.data;
        end
        OP_INC: begin
          state_nxt = ST_INC;
          cnt_nxt   = head.data;
          load_nxt  = 1'b0;
          inc_nxt   = 1'b1;
        end
        OP_WAIT: begin
          state_nxt = ST_WAIT;
          cnt_nxt   = head.data;
          load_nxt  = 1'b0;
          inc_nxt   = 1'b0;
        end
        default: begin
          state_nxt = ST_WAIT;
          cnt_nxt   = 8'd1;
          load_nxt  = 1'b0;
          inc_nxt   = 1'b0;
        end
      endcase
    end else if (last_cycle) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = 8'd0;
      load_nxt  = 1'b0;
      inc_nxt   = 1'b0;
    end else if (state != ST_IDLE) begin
      cnt_nxt = cnt - 8'd1;
    end
  end

  // State and output registers; reset aborts any run and clears the strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= 8'd0;
      o_inc  <= 1'b0;
      o_load <= 1'b0;
      o_d_in <= 8'h00;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      o_inc  <= inc_nxt;
      o_load <= load_nxt;
      o_d_in <= d_in_nxt;
    end
  end

endmodule

// File: tb/tb_cntr8_cmd_seq.sv
// Self-checking bench for cntr8_cmd_seq against a queue-based command/expansion model.
// Latency: model predicts outputs per cycle, sampled on the falling edge.
// Backpressure: model refuses pushes when its queue holds DEPTH commands.
module tb_cntr8_cmd_seq;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_valid;
  logic [1:0]    i_op;
  logic [7:0]    i_data;
  logic          o_ready;
  logic          o_inc;
  logic          o_load;
  logic [7:0]    o_d_in;
  logic          o_busy;
  logic [AW:0]   o_level;

  cntr8_cmd_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_op    (i_op),
    .i_data  (i_data),
    .o_inc   (o_inc),
    .o_load  (o_load),
    .o_d_in  (o_d_in),
    .o_busy  (o_busy),
    .o_level (o_level)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: queued commands, and the per-cycle strobe list of the running command
  logic [9:0]  m_q[$];
  logic [1:0]  m_x[$];   // bit1 = load, bit0 = inc
  logic [7:0]  m_d = 8'h00;

  logic [7:0]  cntr8 = 8'h00;
  bit          watch_ca = 0;
  bit          seen_ca = 0;
  int          inc_seen = 0;
  int          load_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit         acc;
    bit         pp;
    logic [9:0] c;
    int         n;
    if (reset) begin
      m_q.delete();
      m_x.delete();
      m_d = 8'h00;
    end else begin
      acc = i_valid && (m_q.size() < DEPTH);
      pp  = (m_q.size() > 0) && (m_x.size() <= 1);
      if (pp) begin
        c = m_q.pop_front();
        n = (c[7:0] == 8'd0) ? 256 : int'(c[7:0]);
        m_x.delete();
        case (c[9:8])
          2'b01: begin m_x.push_back(2'b10); m_d = c[7:0]; end
          2'b10: repeat (n) m_x.push_back(2'b01);
          2'b11: repeat (n) m_x.push_back(2'b00);
          default: m_x.push_back(2'b00);
        endcase
      end else if (m_x.size() > 0) begin
        void'(m_x.pop_front());
      end
      if (acc) m_q.push_back({i_op, i_data});
    end
  endtask

  task automatic tick();
    logic [1:0] e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = (m_x.size() > 0) ? m_x[0] : 2'b00;
    chk("inc",   o_inc,   e[0]);
    chk("load",  o_load,  e[1]);
    chk("d_in",  o_d_in,  m_d);
    chk("level", o_level, m_q.size());
    chk("ready", o_ready, m_q.size() < DEPTH);
    chk("busy",  o_busy,  (m_x.size() != 0) || (m_q.size() != 0));
    chk("excl",  o_inc && o_load, 0);
    if (o_inc)  inc_seen++;
    if (o_load) load_seen++;
    if (watch_ca && o_load && o_d_in == 8'hCA) begin
      chk("cntr8_before_ca", cntr8, 8'h0F);
      seen_ca  = 1;
      watch_ca = 0;
    end
    if (reset)       cntr8 = 8'h00;
    else if (o_load) cntr8 = o_d_in;
    else if (o_inc)  cntr8 = cntr8 + 8'd1;
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [7:0] d);
    i_valid = v;
    i_op    = op;
    i_data  = d;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'($urandom), 8'($urandom));
  endtask

  initial begin
    int lat;
    int pc;
    int run;
    int best;
    reset   = 1'b1;
    i_valid = 1'b0;
    i_op    = 2'b00;
    i_data  = 8'h00;
    tick();
    tick();
    chk("rst_level", o_level, 0);
    chk("rst_ready", o_ready, 1);
    reset = 1'b0;
    idle(2);

    // Single LOAD: strobe one idle cycle after the acceptance tick
    drive(1'b1, 2'b01, 8'h0C);
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      if (o_load && lat == 0) lat = i;
    end
    chk("t1_latency", lat, 1);
    chk("t1_busy_low", o_busy, 0);

    // LOAD 0C, INC 3, LOAD CA back-to-back
    watch_ca = 1;
    drive(1'b1, 2'b01, 8'h0C);
    drive(1'b1, 2'b10, 8'h03);
    drive(1'b1, 2'b01, 8'hCA);
    idle(10);
    chk("t2_ca_seen", seen_ca, 1);

    // Fill the FIFO behind a long WAIT; fifth push refused
    drive(1'b1, 2'b11, 8'h10);
    idle(2);
    drive(1'b1, 2'b01, 8'h01);
    drive(1'b1, 2'b10, 8'h02);
    drive(1'b1, 2'b11, 8'h01);
    drive(1'b1, 2'b00, 8'h00);
    drive(1'b1, 2'b01, 8'hEE);
    chk("t3_level", o_level, 4);
    chk("t3_ready", o_ready, 0);
    idle(40);
    chk("t3_refused", o_d_in, 8'h01);

    // INC 0 -> 256 consecutive pulses
    drive(1'b1, 2'b10, 8'h00);
    run = 0;
    best = 0;
    for (int i = 0; i < 270; i++) begin
      idle(1);
      if (o_inc) run++; else run = 0;
      if (run > best) best = run;
    end
    chk("t4_inc_run", best, 256);

    // Reset mid-run after 5 pulses with two commands queued
    inc_seen = 0;
    drive(1'b1, 2'b10, 8'h20);
    drive(1'b1, 2'b01, 8'h55);
    drive(1'b1, 2'b01, 8'h66);
    pc = 0;
    while (inc_seen < 5 && pc < 40) begin
      idle(1);
      pc++;
    end
    chk("t5_pulses", inc_seen, 5);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("t5_inc", o_inc, 0);
    chk("t5_level", o_level, 0);
    load_seen = 0;
    idle(40);
    chk("t5_no_loads", load_seen, 0);

    // Push and pop on the same edge at level 2
    drive(1'b1, 2'b11, 8'h03);
    drive(1'b1, 2'b01, 8'h11);
    drive(1'b1, 2'b10, 8'h02);
    idle(1);
    chk("t6_level_pre", o_level, 2);
    drive(1'b1, 2'b01, 8'h22);
    chk("t6_level", o_level, 2);
    idle(20);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      drive(1'($urandom_range(0, 1)), 2'($urandom),
            ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom_range(1, 5)));
    end
    reset = 1'b0;
    pc = 0;
    while (o_busy && pc < 1500) begin
      idle(1);
      pc++;
    end
    chk("drain", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cntr8_cmd_seq.md
Name: cntr8_cmd_seq

Overview:
Command sequencer directly upstream of the 8-bit loadable counter (cntr8). It buffers up to DEPTH counter commands received over a valid/ready handshake. It then replays them as the cycle-accurate inc/load/d_in strobes the counter samples every clock. Typical uses are a preload followed by a run of N increments, and idle gaps between operations.

Parameters:
DEPTH, 4, command FIFO entries (power of two, >=2)
AW, 2, FIFO pointer width, log2(DEPTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_valid  input  1  command present on i_op/i_data
o_ready  output  1  FIFO can accept a command this cycle
i_op  input  2  command opcode: 00 NOP, 01 LOAD, 10 INC, 11 WAIT
i_data  input  8  LOAD value, or INC/WAIT cycle count
o_inc  output  1  to cntr8 inc
o_load  output  1  to cntr8 load
o_d_in  output  8  to cntr8 d_in
o_busy  output  1  executor active or FIFO non-empty
o_level  output  AW+1  current FIFO occupancy, 0..DEPTH

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: FIFO emptied, o_level=0, o_ready=1, executor in IDLE, o_inc=0, o_load=0, o_d_in=8'h00, o_busy=0.
- Reset asserted mid-run aborts the run and flushes all queued commands. Outputs are 0 from the edge where reset is sampled.
- Push: a command is accepted on an edge where i_valid && o_ready.
- o_ready = !full. It is not relieved by a same-cycle pop, so a full FIFO always refuses.
- i_op/i_data are ignored when not accepted.
- Pop: occurs on an edge when the FIFO is non-empty and the executor is in IDLE or in the last cycle of its current command.
- Push and pop may occur on the same edge; o_level is then unchanged.
- There is no bypass. A command accepted into an empty FIFO is popped on the following edge, so its first output cycle is 2 cycles after the acceptance cycle.
- Consecutive queued commands execute back-to-back with no bubble.
- All of o_inc, o_load and o_d_in are registers loaded at the pop edge or by the run counter.
- Executor FSM states: IDLE, LOAD, INC, WAIT. A NOP pop enters WAIT with count 1.
- LOAD: o_load=1 and o_d_in=i_data for exactly 1 cycle, o_inc=0. o_d_in holds that value afterwards until the next LOAD.
- INC: o_inc=1 for exactly N cycles, o_load=0. N = i_data, except i_data=0 means N=256.
- WAIT: o_inc=o_load=0 for N cycles with the same N rule. NOP gives 1 idle cycle.
- An 8-bit down-counter tracks the remaining cycles. The command ends when the count reaches 1.
- After the last command completes with the FIFO empty, the executor returns to IDLE and outputs go to 0 (o_d_in holds).
- o_inc and o_load are never asserted in the same cycle.
- Pointers wrap modulo DEPTH. Full is detected as o_level==DEPTH and empty as o_level==0.
- o_busy = (state!=IDLE) || (o_level!=0).

Decomposition:
- Package cntr8_cmd_pkg: opcode constants OP_NOP/OP_LOAD/OP_INC/OP_WAIT and the executor state encoding.
- Package cntr8_cmd_pkg: the 10-bit command word layout {op[9:8], data[7:0]}.
- Sub-module cmd_fifo: synchronous single-clock FIFO, parameterised DEPTH/width, with push/pop/full/empty/level.
- The executor FSM and run counter stay in cntr8_cmd_seq.

Test Plan:
- Reset then single LOAD 8'h0C -> o_load=1, o_d_in=8'h0C in exactly one cycle, 2 cycles after acceptance. o_busy falls one cycle later.
- LOAD 8'h0C, then INC 3, then LOAD 8'hCA queued back-to-back -> sequence load, inc, inc, inc, load with no gaps. cntr8 downstream reads 8'h0F before the second load.
- Push 5 commands while executor is stalled in WAIT 8'h10 -> o_ready=0 after 4, 5th refused and not executed. o_level=4.
- INC with i_data=0 -> o_inc high for exactly 256 consecutive cycles.
- Reset asserted during INC 8'h20 after 5 pulses with 2 queued -> o_inc=0 next cycle, o_level=0, queued commands never issued.
- Simultaneous push and pop at o_level=2 -> o_level stays 2, order preserved (FIFO order checked by a scoreboard).
